c157x_sd_server: RTL and testbench

//  Responder end of the drive block-transfer interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*).

---
 rtl/c157x_sd_server.sv | 150 +++++++++++++++
 tb/tb_c157x_sd_server.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/c157x_sd_server.sv
// c157x_sd_server: RAM-backed responder that moves 157x drive track blocks
// between the drive track buffer and a byte-wide disk image memory.
module c157x_sd_server #(
    parameter int BLK_BYTES = 256,
    parameter int MEM_AW    = 20
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [31:0]       img_size_i,
    input  logic [31:0]       sd_lba_i,
    input  logic [5:0]        sd_blk_cnt_i,
    input  logic              sd_rd_i,
    input  logic              sd_wr_i,
    output logic              sd_ack_o,
    output logic [15:0]       sd_buff_addr_o,
    output logic [7:0]        sd_buff_dout_o,
    output logic              sd_buff_wr_o,
    input  logic [7:0]        sd_buff_din_i,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o
);
    localparam int OW = $clog2(BLK_BYTES);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_RD_REQ  = 4'd1;
    localparam logic [3:0] ST_RD_WAIT = 4'd2;
    localparam logic [3:0] ST_RD_PUT  = 4'd3;
    localparam logic [3:0] ST_WR_ADDR = 4'd4;
    localparam logic [3:0] ST_WR_SET  = 4'd5;
    localparam logic [3:0] ST_WR_CAP  = 4'd6;
    localparam logic [3:0] ST_WR_MEM  = 4'd7;
    localparam logic [3:0] ST_WR_WAIT = 4'd8;
    localparam logic [3:0] ST_DONE    = 4'd9;

    logic [3:0]    state_q, state_d;
    logic [31:0]   lba_q, lba_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          rd_q, rd_d;
    logic [5:0]    blk_q, blk_d;
    logic [OW-1:0] off_q, off_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;

    logic [31:0] cur_blk;
    logic        in_range;
    logic        last_byte;
    logic        advance;

    // Range check uses the full 32-bit block number, before address truncation.
    assign cur_blk   = lba_q + 32'(blk_q);
    assign in_range  = cur_blk < (img_size_i >> OW);
    assign last_byte = (blk_q == cnt_q) && (&off_q);
    assign advance   = (state_q == ST_RD_PUT) ||
                       (state_q == ST_WR_MEM && !in_range) ||
                       (state_q == ST_WR_WAIT && mem_ack_i);

    always_comb begin
        state_d = state_q;
        lba_d   = lba_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        blk_d   = blk_q;
        off_d   = off_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (sd_rd_i || sd_wr_i) begin
                    lba_d   = sd_lba_i;
                    cnt_d   = sd_blk_cnt_i;
                    rd_d    = sd_rd_i;
                    err_d   = 1'b0;
                    state_d = sd_rd_i ? ST_RD_REQ : ST_WR_ADDR;
                end
            end
            ST_RD_REQ: begin
                if (in_range) begin
                    state_d = ST_RD_WAIT;
                end else begin
                    data_d  = 8'h00;
                    err_d   = 1'b1;
                    state_d = ST_RD_PUT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_ack_i) begin
                    data_d  = mem_rdata_i;
                    state_d = ST_RD_PUT;
                end
            end
            ST_WR_ADDR: state_d = ST_WR_SET;
            ST_WR_SET:  state_d = ST_WR_CAP;
            ST_WR_CAP: begin
                data_d  = sd_buff_din_i;
                state_d = ST_WR_MEM;
            end
            ST_WR_MEM: begin
                if (in_range) state_d = ST_WR_WAIT;
                else err_d = 1'b1;
            end
            ST_RD_PUT, ST_WR_WAIT: ;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            off_d   = off_q + OW'(1);
            blk_d   = (&off_q) ? (last_byte ? 6'd0 : blk_q + 6'd1) : blk_q;
            state_d = last_byte ? ST_DONE : (rd_q ? ST_RD_REQ : ST_WR_ADDR);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            lba_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            blk_q   <= '0;
            off_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lba_q   <= lba_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            blk_q   <= blk_d;
            off_q   <= off_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign sd_ack_o       = state_q != ST_IDLE;
    assign sd_buff_wr_o   = state_q == ST_RD_PUT;
    assign mem_req_o      = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
    assign mem_we_o       = state_q == ST_WR_WAIT;
    assign sd_buff_addr_o = 16'({blk_q, off_q});
    assign sd_buff_dout_o = data_q;
    assign mem_addr_o     = MEM_AW'({cur_blk, off_q});
    assign mem_wdata_o    = data_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_c157x_sd_server.sv
// tb_c157x_sd_server: vector table plus scoreboard bench for the block-transfer responder.
module tb_c157x_sd_server;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] img_size;
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;
    logic        sd_rd, sd_wr;
    logic        sd_ack;
    logic [15:0] sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [19:0] mem_addr;
    logic        mem_req, mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        err;

    c157x_sd_server #(.BLK_BYTES(256), .MEM_AW(20)) dut (
        .clk_i(clk), .reset_i(reset), .img_size_i(img_size), .sd_lba_i(sd_lba),
        .sd_blk_cnt_i(sd_blk_cnt), .sd_rd_i(sd_rd), .sd_wr_i(sd_wr), .sd_ack_o(sd_ack),
        .sd_buff_addr_o(sd_buff_addr), .sd_buff_dout_o(sd_buff_dout), .sd_buff_wr_o(sd_buff_wr),
        .sd_buff_din_i(sd_buff_din), .mem_addr_o(mem_addr), .mem_req_o(mem_req),
        .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .mem_ack_i(mem_ack), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] lba;
        logic [5:0]  cnt;
        logic [31:0] img;
        logic        dly;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } exp_t;

    logic [7:0] mem     [0:(1<<20)-1];
    logic [7:0] ref_mem [0:(1<<20)-1];
    logic [7:0] tbuf    [0:65535];
    exp_t       rdq[$];
    exp_t       wrq[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         buff_cnt = 0;
    int         memw_cnt = 0;
    int         req_drop = 0;
    int         wcnt = 0;
    logic       rand_dly = 1'b0;
    logic       prev_err = 1'b0;
    logic       prev_req = 1'b0;
    logic       prev_ack = 1'b0;
    vec_t       vecs[9];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] lba,
                                input logic [5:0] cnt, input logic [31:0] img,
                                input logic dly, input logic ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.lba = lba; v.cnt = cnt; v.img = img; v.dly = dly; v.exp_err = ee;
        return v;
    endfunction

    function automatic int pick_dly();
        int r;
        r = int'($urandom_range(0, 2));
        return (r == 0) ? 0 : (r == 1) ? 1 : 7;
    endfunction

    // Image memory: acks a held request after 0, 1 or 7 extra clocks.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ack <= 1'b0;
            wcnt    <= 0;
        end else begin
            mem_ack <= 1'b0;
            if (mem_req && !mem_ack) begin
                if (wcnt == 0) begin
                    mem_ack <= 1'b1;
                    if (mem_we) mem[mem_addr] <= mem_wdata;
                    else mem_rdata <= mem[mem_addr];
                    wcnt <= rand_dly ? pick_dly() : 0;
                end else begin
                    wcnt <= wcnt - 1;
                end
            end
        end
    end

    always @(posedge clk) sd_buff_din <= tbuf[sd_buff_addr];

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (sd_buff_wr) begin
                buff_cnt++;
                chk("buff_wr_expected", 32'(rdq.size() != 0), 32'd1);
                if (rdq.size() != 0) begin
                    e = rdq.pop_front();
                    chk("rd_byte", {sd_buff_addr, 8'h00, sd_buff_dout}, {e.a[15:0], 8'h00, e.d});
                end
            end
            if (mem_req && mem_we && mem_ack) begin
                memw_cnt++;
                chk("mem_wr_expected", 32'(wrq.size() != 0), 32'd1);
                if (wrq.size() != 0) begin
                    e = wrq.pop_front();
                    chk("wr_byte", {4'h0, mem_addr, mem_wdata}, {4'h0, e.a[19:0], e.d});
                end
            end
            if (prev_req && !prev_ack && !mem_req) req_drop++;
            prev_req = mem_req;
            prev_ack = mem_ack;
        end else begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end
    end

    task automatic push_exp(input vec_t v, input logic rd, output int n);
        n = 0;
        for (int b = 0; b <= int'(v.cnt); b++) begin
            for (int o = 0; o < 256; o++) begin
                logic [31:0] cur, ba;
                logic        inr;
                exp_t        e;
                cur = v.lba + 32'(b);
                inr = cur < (v.img >> 8);
                ba  = (cur << 8) + 32'(o);
                if (rd) begin
                    e.a = 32'(16'(b * 256 + o));
                    e.d = inr ? ref_mem[ba[19:0]] : 8'h00;
                    rdq.push_back(e);
                    n++;
                end else if (inr) begin
                    e.a = {12'h0, ba[19:0]};
                    e.d = tbuf[16'(b * 256 + o)];
                    ref_mem[ba[19:0]] = e.d;
                    wrq.push_back(e);
                    n++;
                end
            end
        end
    endtask

    task automatic wait_ack(input logic lvl, input string nm);
        for (int i = 0; i < 10000 && sd_ack !== lvl; i++) @(negedge clk);
        chk(nm, 32'(sd_ack), 32'(lvl));
    endtask

    task automatic run_vec(input vec_t v);
        int np, nm;
        np = 0;
        nm = 0;
        chk("err_hold", 32'(err), 32'(prev_err));
        img_size = v.img;
        rand_dly = v.dly;
        buff_cnt = 0;
        memw_cnt = 0;
        if (v.rd) push_exp(v, 1'b1, np);
        if (v.wr) push_exp(v, 1'b0, nm);
        @(negedge clk);
        sd_lba = v.lba; sd_blk_cnt = v.cnt; sd_rd = v.rd; sd_wr = v.wr;
        @(negedge clk);
        chk("ack_rise", 32'(sd_ack), 32'd1);
        chk("err_clear", 32'(err), 32'd0);
        sd_rd = 1'b0;
        if (v.rd && v.wr) begin
            wait_ack(1'b0, "rd_ack_fall");
            wait_ack(1'b1, "wr_follow_ack");
        end
        sd_wr = 1'b0;
        sd_lba = 32'hDEAD_BEEF;
        sd_blk_cnt = 6'h3F;
        wait_ack(1'b0, "ack_fall");
        chk("err_end", 32'(err), 32'(v.exp_err));
        chk("buff_wr_count", 32'(buff_cnt), 32'(np));
        chk("mem_wr_count", 32'(memw_cnt), 32'(nm));
        chk("rdq_drained", 32'(rdq.size()), 32'd0);
        chk("wrq_drained", 32'(wrq.size()), 32'd0);
        prev_err = v.exp_err;
    endtask

    initial begin
        int np;
        reset = 1'b1;
        img_size = 32'd174848;
        sd_lba = '0; sd_blk_cnt = '0; sd_rd = 1'b0; sd_wr = 1'b0;
        for (int i = 0; i < (1 << 20); i++) begin
            mem[i] = 8'(i);
            ref_mem[i] = 8'(i);
        end
        for (int i = 0; i < 65536; i++) tbuf[i] = ~8'(i);
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(sd_ack), 32'd0);
        chk("rst_buff_wr", 32'(sd_buff_wr), 32'd0);
        chk("rst_mem_req", {31'd0, mem_req} | {30'd0, mem_we, 1'b0}, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addrs", {sd_buff_addr, 16'h0} | {12'h0, mem_addr}, 32'd0);
        chk("rst_data", {16'h0, sd_buff_dout, mem_wdata}, 32'd0);
        reset = 1'b0;

        vecs[0] = mk(1'b1, 1'b0, 32'd36,         6'd0, 32'd174848,   1'b0, 1'b0);
        vecs[1] = mk(1'b0, 1'b1, 32'd2,          6'd1, 32'd174848,   1'b0, 1'b0);
        vecs[2] = mk(1'b1, 1'b0, 32'd682,        6'd1, 32'd174848,   1'b0, 1'b1);
        vecs[3] = mk(1'b1, 1'b0, 32'd36,         6'd0, 32'd174848,   1'b1, 1'b0);
        vecs[4] = mk(1'b1, 1'b1, 32'd10,         6'd0, 32'd174848,   1'b0, 1'b0);
        vecs[5] = mk(1'b1, 1'b0, 32'd0,          6'd0, 32'd0,        1'b0, 1'b1);
        vecs[6] = mk(1'b0, 1'b1, 32'd682,        6'd1, 32'd174848,   1'b1, 1'b1);
        vecs[7] = mk(1'b1, 1'b0, 32'd4095,       6'd2, 32'hFFFFFFFF, 1'b0, 1'b0);
        vecs[8] = mk(1'b1, 1'b0, 32'hFFFFFFFF,   6'd1, 32'hFFFFFFFF, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the middle of byte 100 of a read, then a clean restart.
        img_size = 32'd174848;
        rand_dly = 1'b0;
        buff_cnt = 0;
        push_exp(mk(1'b1, 1'b0, 32'd36, 6'd0, 32'd174848, 1'b0, 1'b0), 1'b1, np);
        @(negedge clk);
        sd_lba = 32'd36; sd_blk_cnt = 6'd0; sd_rd = 1'b1;
        @(negedge clk);
        sd_rd = 1'b0;
        for (int i = 0; i < 5000 && buff_cnt < 100; i++) @(negedge clk);
        chk("mid_pulses", 32'(buff_cnt), 32'd100);
        for (int i = 0; i < 100 && !mem_req; i++) @(negedge clk);
        chk("mid_req_up", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(sd_ack), 32'd0);
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_buff_wr", 32'(sd_buff_wr), 32'd0);
        chk("mid_rst_addr", 32'(sd_buff_addr), 32'd0);
        rdq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prev_err = 1'b0;
        run_vec(mk(1'b1, 1'b0, 32'd36, 6'd0, 32'd174848, 1'b0, 1'b0));

        chk("mem_req_held_to_ack", 32'(req_drop), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
